// File: rtl/btb_write_scheduler_pkg.sv
// Shared types and constants for the BTB write scheduler.
// Geometry is fixed here so the FIFO entry struct has concrete widths.
package btb_write_scheduler_pkg;

   localparam int BTB_ENTRY_NUM  = 512;
   localparam int BTB_IDX_W      = $clog2(BTB_ENTRY_NUM);
   localparam int BTB_BANK_NUM   = 2;
   localparam int BTB_BANK_W     = (BTB_BANK_NUM > 1) ? $clog2(BTB_BANK_NUM) : 1;
   localparam int BTB_WRITE_NUM  = 2;
   localparam int BTB_ENTRY_BITS = 48;

   localparam int BTB_WRITE_SCHED_QUEUE_DEPTH = 4;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      FLUSH
   } BTBWriteSchedState;

   typedef struct packed {
      logic [BTB_IDX_W-1:0]      index;
      logic [BTB_ENTRY_BITS-1:0] entry;
   } BTBWriteReq;

   // Bank is the low index bits; modulo keeps it legal for any power-of-2 bank count.
   function automatic logic [BTB_BANK_W-1:0] ToBTB_Bank(
      input logic [BTB_IDX_W-1:0] index
   );
      return BTB_BANK_W'(index % BTB_IDX_W'(BTB_BANK_NUM));
   endfunction

endpackage

// File: rtl/btb_write_sched_queue.sv
// Deferred-write FIFO for bank-conflicting BTB updates.
// Supports push and pop in the same cycle even when full.
module btb_write_sched_queue
   import btb_write_scheduler_pkg::*;
#(
   parameter int DEPTH = BTB_WRITE_SCHED_QUEUE_DEPTH
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clear,
   input  logic       i_push,
   input  BTBWriteReq i_push_data,
   input  logic       i_pop,
   output BTBWriteReq o_head,
   output logic       o_empty,
   output logic       o_full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   BTBWriteReq       r_mem [DEPTH];

   logic w_do_push;
   logic w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty && !i_clear;
   assign w_do_push = i_push && !i_clear && (!o_full || w_do_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/btb_write_scheduler.sv
// Write-side scheduler for the banked BTB: clear sweep, conflict deferral, drain.
// Define BTB_WRITE_SCHED_STATS_EN to build the saturating conflict/drop counters.
module btb_write_scheduler
   import btb_write_scheduler_pkg::*;
(
   input  logic                                    i_clk,
   input  logic                                    i_rst,
   input  logic                                    i_flush_req,
   input  logic [BTB_WRITE_NUM-1:0]                i_req_valid,
   input  logic [BTB_WRITE_NUM*BTB_IDX_W-1:0]      i_req_index,
   input  logic [BTB_WRITE_NUM*BTB_ENTRY_BITS-1:0] i_req_entry,
   output logic [BTB_WRITE_NUM-1:0]                o_ram_we,
   output logic [BTB_WRITE_NUM*BTB_IDX_W-1:0]      o_ram_wa,
   output logic [BTB_WRITE_NUM*BTB_ENTRY_BITS-1:0] o_ram_wv,
   output logic                                    o_ready,
   output logic                                    o_queue_full,
   output logic                                    o_drop,
   output logic [15:0]                             o_conflict_count,
   output logic [15:0]                             o_drop_count
);

   localparam int WN        = BTB_WRITE_NUM;
   localparam int IW        = BTB_IDX_W;
   localparam int EB        = BTB_ENTRY_BITS;
   localparam int SWEEP_W   = IW + 1;
   localparam int DROP_W    = $clog2(WN + 1);
   localparam logic [SWEEP_W-1:0] SWEEP_END = SWEEP_W'(BTB_ENTRY_NUM);

   BTBWriteSchedState r_state;
   BTBWriteSchedState w_state_nxt;
   logic [SWEEP_W-1:0] r_sweep;
   logic [SWEEP_W-1:0] w_sweep_nxt;
   logic               w_sweep_we;
   logic [IW-1:0]      w_sweep_wa;
   logic               w_run;
   logic               w_fifo_clear;

   logic [BTB_BANK_W-1:0] w_bank [WN];
   logic [BTB_BANK_W-1:0] w_head_bank;
   logic [WN-1:0]         w_gnt;
   logic [WN-1:0]         w_conf;
   logic [WN-1:0]         w_pop_sel;
   logic                  w_head_blocked;
   logic                  w_pop;
   logic                  w_push;
   logic [DROP_W-1:0]     w_drop_num;
   BTBWriteReq            w_push_data;
   BTBWriteReq            w_head;
   logic                  w_empty;
   logic                  w_full;

   logic [WN-1:0]    r_we;
   logic [WN*IW-1:0] r_wa;
   logic [WN*EB-1:0] r_wv;
   logic             r_drop;
   logic [WN-1:0]    w_we_nxt;
   logic [WN*IW-1:0] w_wa_nxt;
   logic [WN*EB-1:0] w_wv_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= INIT;
         r_sweep <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sweep <= w_sweep_nxt;
      end
   end

   // A flush restarts the sweep by issuing index 0 in the same cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_sweep_nxt  = r_sweep;
      w_sweep_we   = 1'b0;
      w_sweep_wa   = '0;
      w_run        = 1'b0;
      w_fifo_clear = 1'b0;
      if (i_flush_req) begin
         w_state_nxt  = (r_state == RUN) ? FLUSH : r_state;
         w_sweep_we   = 1'b1;
         w_sweep_wa   = '0;
         w_sweep_nxt  = SWEEP_W'(1);
         w_fifo_clear = 1'b1;
      end else begin
         unique case (r_state)
            RUN: begin
               w_run = 1'b1;
            end
            INIT, FLUSH: begin
               if (r_sweep == SWEEP_END) begin
                  w_state_nxt = RUN;
                  w_sweep_nxt = '0;
               end else begin
                  w_sweep_we  = 1'b1;
                  w_sweep_wa  = r_sweep[IW-1:0];
                  w_sweep_nxt = r_sweep + 1'b1;
               end
            end
            default: begin
               w_state_nxt = INIT;
               w_sweep_nxt = '0;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < WN; i++) begin
         w_bank[i] = ToBTB_Bank(i_req_index[i*IW +: IW]);
      end
      w_head_bank = ToBTB_Bank(w_head.index);
   end

   always_comb begin
      w_gnt          = '0;
      w_conf         = '0;
      w_pop_sel      = '0;
      w_head_blocked = 1'b0;
      w_pop          = 1'b0;
      w_push         = 1'b0;
      w_push_data    = '0;
      w_drop_num     = '0;
      if (w_run) begin
         for (int i = 0; i < WN; i++) begin
            if (i_req_valid[i]) begin
               w_gnt[i] = 1'b1;
               for (int j = 0; j < i; j++) begin
                  if (w_gnt[j] && (w_bank[j] == w_bank[i])) w_gnt[i] = 1'b0;
               end
               w_conf[i] = !w_gnt[i];
            end
         end
         for (int i = 0; i < WN; i++) begin
            if (w_gnt[i] && (w_bank[i] == w_head_bank)) w_head_blocked = 1'b1;
         end
         // Head drains to the lowest port left idle by direct grants.
         if (!w_empty && !w_head_blocked) begin
            for (int i = 0; i < WN; i++) begin
               if (!w_gnt[i] && !w_pop) begin
                  w_pop        = 1'b1;
                  w_pop_sel[i] = 1'b1;
               end
            end
         end
         for (int i = 0; i < WN; i++) begin
            if (w_conf[i]) begin
               if (!w_push && (!w_full || w_pop)) begin
                  w_push            = 1'b1;
                  w_push_data.index = i_req_index[i*IW +: IW];
                  w_push_data.entry = i_req_entry[i*EB +: EB];
               end else begin
                  w_drop_num = w_drop_num + DROP_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      w_we_nxt = '0;
      w_wa_nxt = '0;
      w_wv_nxt = '0;
      if (w_sweep_we) begin
         w_we_nxt[0]       = 1'b1;
         w_wa_nxt[IW-1:0]  = w_sweep_wa;
      end
      for (int i = 0; i < WN; i++) begin
         if (w_gnt[i]) begin
            w_we_nxt[i]          = 1'b1;
            w_wa_nxt[i*IW +: IW] = i_req_index[i*IW +: IW];
            w_wv_nxt[i*EB +: EB] = i_req_entry[i*EB +: EB];
         end else if (w_pop_sel[i]) begin
            w_we_nxt[i]          = 1'b1;
            w_wa_nxt[i*IW +: IW] = w_head.index;
            w_wv_nxt[i*EB +: EB] = w_head.entry;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_we   <= '0;
         r_wa   <= '0;
         r_wv   <= '0;
         r_drop <= 1'b0;
      end else begin
         r_we   <= w_we_nxt;
         r_wa   <= w_wa_nxt;
         r_wv   <= w_wv_nxt;
         r_drop <= (w_drop_num != '0);
      end
   end

   btb_write_sched_queue #(
      .DEPTH (BTB_WRITE_SCHED_QUEUE_DEPTH)
   ) u_queue (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (w_fifo_clear),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_empty     (w_empty),
      .o_full      (w_full)
   );

   assign o_ram_we     = r_we;
   assign o_ram_wa     = r_wa;
   assign o_ram_wv     = r_wv;
   assign o_ready      = (r_state == RUN);
   assign o_queue_full = w_full;
   assign o_drop       = r_drop;

`ifdef BTB_WRITE_SCHED_STATS_EN
   logic [15:0] r_conflict_count;
   logic [15:0] r_drop_count;
   logic [16:0] w_drop_sum;

   assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_num);

   // Counters survive flush; only reset clears them.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_conflict_count <= '0;
         r_drop_count     <= '0;
      end else begin
         if (w_push && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
         end
         r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
   end

   assign o_conflict_count = r_conflict_count;
   assign o_drop_count     = r_drop_count;
`else
   assign o_conflict_count = '0;
   assign o_drop_count     = '0;
`endif

endmodule

// File: tb/tb_btb_write_scheduler.sv
// Scoreboard bench for btb_write_scheduler: random updates vs. a queue-based model.
// Covers the clear sweep, direct/deferred writes, full/drop, flush and mid-sweep reset.
module tb_btb_write_scheduler;

   localparam int N  = 512;
   localparam int IW = 9;
   localparam int EB = 48;
   localparam int WN = 2;
   localparam int QD = 4;
`ifdef BTB_WRITE_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush_req = 1'b0;
   logic [WN-1:0]     req_valid = '0;
   logic [WN*IW-1:0]  req_index = '0;
   logic [WN*EB-1:0]  req_entry = '0;
   logic [WN-1:0]     ram_we;
   logic [WN*IW-1:0]  ram_wa;
   logic [WN*EB-1:0]  ram_wv;
   logic              ready;
   logic              queue_full;
   logic              drop;
   logic [15:0]       conflict_count;
   logic [15:0]       drop_count;

   always #5 clk = ~clk;

   btb_write_scheduler dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_flush_req      (flush_req),
      .i_req_valid      (req_valid),
      .i_req_index      (req_index),
      .i_req_entry      (req_entry),
      .o_ram_we         (ram_we),
      .o_ram_wa         (ram_wa),
      .o_ram_wv         (ram_wv),
      .o_ready          (ready),
      .o_queue_full     (queue_full),
      .o_drop           (drop),
      .o_conflict_count (conflict_count),
      .o_drop_count     (drop_count)
   );

   typedef struct {
      logic [WN-1:0]    we;
      logic [WN*IW-1:0] wa;
      logic [WN*EB-1:0] wv;
      logic             ready;
      logic             full;
      logic             drop;
      logic [15:0]      cc;
      logic [15:0]      dc;
   } exp_t;

   typedef struct {
      int          idx;
      logic [47:0] ent;
   } fent_t;

   exp_t  expq[$];
   fent_t fifo[$];
   bit    running = 0;
   int    pos = 0;
   int    pushes = 0;
   int    drops = 0;
   int    n_vec = 0;
   int    n_err = 0;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] sat16(input int v);
      logic [15:0] r;
      r = (v > 65535) ? 16'hFFFF : v[15:0];
      return STATS ? r : 16'h0;
   endfunction

   // Reference model: one call per clock, returns what the outputs must show after it.
   task automatic model_step(input bit r, input bit f, input logic [WN-1:0] v,
                             input logic [WN*IW-1:0] ix, input logic [WN*EB-1:0] en,
                             output exp_t e);
      int    pidx [WN];
      bit    g [WN];
      int    sz;
      int    nd;
      bit    popped;
      bit    pushed;
      fent_t head;
      fent_t ne;
      e.we = '0; e.wa = '0; e.wv = '0; e.drop = 1'b0;
      if (r) begin
         running = 0; pos = 0; fifo.delete(); pushes = 0; drops = 0;
      end else if (f) begin
         fifo.delete(); running = 0;
         e.we[0] = 1'b1; pos = 1;
      end else if (!running) begin
         if (pos < N) begin
            e.we[0] = 1'b1; e.wa[IW-1:0] = pos[IW-1:0]; pos++;
         end else begin
            running = 1;
         end
      end else begin
         for (int p = 0; p < WN; p++) begin
            pidx[p] = int'(ix[p*IW +: IW]);
            g[p] = v[p];
            for (int q = 0; q < p; q++)
               if (v[q] && g[q] && (pidx[q] % 2 == pidx[p] % 2)) g[p] = 0;
            if (g[p]) begin
               e.we[p] = 1'b1;
               e.wa[p*IW +: IW] = ix[p*IW +: IW];
               e.wv[p*EB +: EB] = en[p*EB +: EB];
            end
         end
         sz = fifo.size(); popped = 0; pushed = 0; nd = 0;
         if (sz > 0) begin
            bit blocked = 0;
            head = fifo[0];
            for (int p = 0; p < WN; p++)
               if (g[p] && (pidx[p] % 2 == head.idx % 2)) blocked = 1;
            for (int p = 0; p < WN; p++) begin
               if (!blocked && !popped && !g[p]) begin
                  popped = 1;
                  e.we[p] = 1'b1;
                  e.wa[p*IW +: IW] = head.idx[IW-1:0];
                  e.wv[p*EB +: EB] = head.ent;
               end
            end
            if (popped) void'(fifo.pop_front());
         end
         for (int p = 0; p < WN; p++) begin
            if (v[p] && !g[p]) begin
               if (!pushed && (sz < QD || popped)) begin
                  ne.idx = pidx[p]; ne.ent = en[p*EB +: EB];
                  fifo.push_back(ne); pushed = 1; pushes++;
               end else begin
                  nd++; drops++;
               end
            end
         end
         e.drop = (nd > 0);
      end
      e.ready = running;
      e.full  = (fifo.size() == QD);
      e.cc    = sat16(pushes);
      e.dc    = sat16(drops);
   endtask

   task automatic drive(input bit r, input bit f, input logic [WN-1:0] v,
                        input logic [WN*IW-1:0] ix, input logic [WN*EB-1:0] en);
      exp_t e;
      bit   prev;
      @(negedge clk);
      prev = rst;
      rst = r; flush_req = f; req_valid = v; req_index = ix; req_entry = en;
      model_step(r, f, v, ix, en, e);
      expq.push_back(e);
      if (r && !prev) begin
         #1;
         check("async_rst_we", 128'(ram_we), 128'(0));
         check("async_rst_wa", 128'(ram_wa), 128'(0));
         check("async_rst_wv", 128'(ram_wv), 128'(0));
         check("async_rst_ready", 128'(ready), 128'(0));
         check("async_rst_full", 128'(queue_full), 128'(0));
         check("async_rst_drop", 128'(drop), 128'(0));
      end
   endtask

   // Random request; bias makes port 1 share port 0's bank more often.
   task automatic rand_req(input int valid_pct, input int same_pct,
                           output logic [WN-1:0] v, output logic [WN*IW-1:0] ix,
                           output logic [WN*EB-1:0] en);
      logic [IW-1:0] a0;
      logic [IW-1:0] a1;
      v[0] = ($urandom_range(99) < valid_pct);
      v[1] = ($urandom_range(99) < valid_pct);
      a0 = IW'($urandom_range(N - 1));
      a1 = IW'($urandom_range(N - 1));
      if ($urandom_range(99) < same_pct) a1[0] = a0[0];
      ix = {a1, a0};
      en = {$urandom, $urandom, $urandom};
   endtask

   always begin
      exp_t e;
      logic [WN*IW-1:0] wam;
      logic [WN*EB-1:0] wvm;
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         wam = '0; wvm = '0;
         for (int p = 0; p < WN; p++) begin
            if (e.we[p]) begin
               wam[p*IW +: IW] = ram_wa[p*IW +: IW];
               wvm[p*EB +: EB] = ram_wv[p*EB +: EB];
            end
         end
         check("ram_we", 128'(ram_we), 128'(e.we));
         check("ram_wa", 128'(wam), 128'(e.wa));
         check("ram_wv", 128'(wvm), 128'(e.wv));
         check("ready", 128'(ready), 128'(e.ready));
         check("queue_full", 128'(queue_full), 128'(e.full));
         check("drop", 128'(drop), 128'(e.drop));
         check("conflict_count", 128'(conflict_count), 128'(e.cc));
         check("drop_count", 128'(drop_count), 128'(e.dc));
      end
   end

   initial begin
      logic [WN-1:0]    v;
      logic [WN*IW-1:0] ix;
      logic [WN*EB-1:0] en;
      logic [IW-1:0]    a0;
      logic [IW-1:0]    a1;
      #1;
      check("reset_we", 128'(ram_we), 128'(0));
      check("reset_ready", 128'(ready), 128'(0));
      check("reset_full", 128'(queue_full), 128'(0));

      repeat (3) drive(1, 0, '0, '0, '0);
      // Power-on sweep with requests arriving that must be ignored.
      for (int c = 0; c < N + 1; c++) begin
         rand_req(80, 50, v, ix, en);
         drive(0, 0, v, ix, en);
      end

      drive(0, 0, 2'b11, {9'h021, 9'h010}, {48'hAAAA_0000_0021, 48'h5555_0000_0011});
      drive(0, 0, 2'b00, '0, '0);
      drive(0, 0, 2'b11, {9'h020, 9'h010}, {48'hBEEF_0000_0021, 48'hCAFE_0000_0011});
      drive(0, 0, 2'b00, '0, '0);
      drive(0, 0, 2'b00, '0, '0);

      // Fill the FIFO with bank-0 conflicts while port 0 keeps bank 0 busy.
      for (int k = 0; k < 5; k++) begin
         a0 = IW'($urandom_range(N - 1)); a0[0] = 1'b0;
         a1 = IW'($urandom_range(N - 1)); a1[0] = 1'b0;
         drive(0, 0, 2'b11, {a1, a0}, {$urandom, $urandom, $urandom});
      end
      repeat (6) drive(0, 0, 2'b00, '0, '0);

      // Flush with two entries pending.
      for (int k = 0; k < 2; k++) begin
         a0 = IW'($urandom_range(N - 1)); a0[0] = 1'b1;
         a1 = IW'($urandom_range(N - 1)); a1[0] = 1'b1;
         drive(0, 0, 2'b11, {a1, a0}, {$urandom, $urandom, $urandom});
      end
      drive(0, 1, 2'b11, {9'h001, 9'h003}, {$urandom, $urandom, $urandom});
      for (int c = 0; c < N + 4; c++) begin
         rand_req(60, 50, v, ix, en);
         drive(0, 0, v, ix, en);
      end

      // Random run, occasional flush.
      for (int c = 0; c < 2500; c++) begin
         rand_req(85, 70, v, ix, en);
         drive(0, ($urandom_range(999) == 0), v, ix, en);
      end

      // Reset asserted mid-sweep around index 200.
      drive(0, 1, '0, '0, '0);
      for (int c = 0; c < 199; c++) drive(0, 0, '0, '0, '0);
      drive(1, 0, 2'b11, {9'h0AA, 9'h055}, '1);
      drive(1, 0, '0, '0, '0);
      for (int c = 0; c < N + 60; c++) begin
         rand_req(85, 70, v, ix, en);
         drive(0, 0, v, ix, en);
      end

      drive(0, 0, '0, '0, '0);
      @(posedge clk);
      #3;
      check("scoreboard_drained", 128'(expq.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/btb_write_scheduler.md
Name: btb_write_scheduler

Overview:
- Write-side controller for the multi-bank BTB entry array.
- Accepts up to WRITE_NUM branch-resolution updates per cycle and detects same-bank conflicts.
- Defers conflicting updates into a small FIFO, then drains that FIFO into idle, non-conflicting write ports.
- Owns the power-on and flush clear sequence: sweeps every entry invalid before the BTB is usable.

Parameters:
ENTRY_NUM, 512, BTB entries; power of 2; IDX_W = log2(ENTRY_NUM)
BANK_NUM, 2, banks; bank = index[log2(BANK_NUM)-1:0]; BANK_NUM >= WRITE_NUM
WRITE_NUM, 2, RAM write ports / update requesters
QUEUE_DEPTH, 4, deferred-write FIFO entries; power of 2, >= 2
ENTRY_BITS, 48, BTB entry payload width; bit 0 = valid

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush_req  in  1  one-cycle pulse; restart the clear sweep
req_valid  in  WRITE_NUM  update request per port (taken, non-approx branch)
req_index  in  WRITE_NUM*IDX_W  target index per port
req_entry  in  WRITE_NUM*ENTRY_BITS  entry value per port
ram_we  out  WRITE_NUM  registered write enables to entry array
ram_wa  out  WRITE_NUM*IDX_W  registered write addresses
ram_wv  out  WRITE_NUM*ENTRY_BITS  registered write values
ready  out  1  1 only in RUN; fetch ignores BTB hits while 0
queue_full  out  1  FIFO holds QUEUE_DEPTH entries
drop  out  1  registered pulse: an update was discarded this cycle
conflict_count  out  16  stats (see Optional Feature)
drop_count  out  16  stats

Behaviour:
- Reset (async): state = INIT, sweep index = 0, FIFO empty, all outputs 0.
- FSM states: INIT, RUN, FLUSH.
  - INIT/FLUSH: each cycle drive ram_we[0]=1, ram_wa[0]=sweep, ram_wv[0]=0; other ports 0; sweep increments.
  - When sweep = ENTRY_NUM-1 is issued, go to RUN next cycle. Sweep length = ENTRY_NUM cycles.
  - RUN + flush_req: go to FLUSH, sweep=0, FIFO cleared. flush_req in INIT/FLUSH restarts sweep at 0.
- Requests while not RUN: discarded silently; drop stays 0 and counters unchanged.
- RUN latency: request in cycle N appears on ram_* at cycle N+1. Registered outputs only; no combinational path input to output.
- Conflict rule, per cycle in ascending port order:
  - Request i is granted on port i unless its bank equals the bank of some granted lower port j.
  - A conflicting request is pushed to the FIFO, at most one push per cycle.
  - A further conflicting request in the same cycle is dropped (drop=1).
- Drain rule: if FIFO not empty, the head goes to the lowest-numbered port i that:
  - carries no granted request, and
  - has a bank that conflicts with no granted port.
  - At most one pop per cycle. If no such port, the head waits.
- Push and pop in the same cycle: allowed even when full; occupancy unchanged, order preserved. Full and no pop: new conflicting request is dropped (drop=1).
- A queued write may land after a newer direct write to the same index. This is accepted, since the BTB is a hint. No index coalescing.
- Pointers wrap modulo QUEUE_DEPTH. queue_full is derived from an occupancy counter of width log2(QUEUE_DEPTH)+1.
- Reset asserted mid-sweep or mid-drain: immediate return to the reset state; pending FIFO contents lost.

Optional Feature:
- Macro: BTB_WRITE_SCHED_STATS_EN.
- Defined: conflict_count increments on each FIFO push, drop_count on each drop. Both are 16-bit saturating (hold at 0xFFFF), async-cleared by rst, and not cleared by flush.
- Undefined: both ports tied to 0 and no counter flops are instantiated.

Decomposition:
- FetchUnitTypes package gets:
  - BTBWriteSchedState enum {INIT, RUN, FLUSH}
  - BTBWriteReq struct {index, entry}
  - function ToBTB_Bank(index)
  - constant BTB_WRITE_SCHED_QUEUE_DEPTH
- One sub-module: btb_write_sched_queue. It is a FIFO of BTBWriteReq with push/pop/clear/full/empty and same-cycle push+pop support.

Test Plan:
- Reset, ENTRY_NUM=512 → ram_we[0]=1 for exactly 512 cycles with addresses 0..511 and data 0; ready rises on cycle 513; requests during the sweep produce no writes.
- RUN, port0 idx 0x10 and port1 idx 0x21 same cycle (banks 0/1) → next cycle both written directly; FIFO stays empty.
- RUN, port0 idx 0x10 and port1 idx 0x20 (both bank 0) → 0x10 written on port 0, 0x20 queued; next idle cycle 0x20 written on port 0, conflict_count=1.
- Fill FIFO with 4 conflicts, then a 5th conflict with port 0 busy on bank 0 (no drain possible) → drop=1, drop_count=1, queue_full=1; FIFO order preserved on drain.
- flush_req while FIFO holds 2 entries → FIFO emptied, ready=0 for 512 cycles, queued writes never issued.
- rst asserted mid-sweep at index 200 → outputs 0 immediately; sweep restarts from 0 after release.
